cv32e40x_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one multi-cycle resource, such as a shared divider or a bus port, among `NUM_REQ` requesters. It finds the first set bit in a priority-rotated request vector, registers a one-hot grant, and holds that grant until the resource signals completion or the grant is killed. After each grant the priority pointer moves past the winner, so every persistent requester is served within `NUM_REQ` grants.

---
 rtl/cv32e40x_rr_arbiter.sv | 107 ++++++++++
 tb/tb_cv32e40x_rr_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cv32e40x_rr_arbiter.sv
// Round-robin arbiter granting one multi-cycle shared resource among NUM_REQ requesters.
// Grant is held until done_i or kill_i; the priority pointer moves past each winner.
module cv32e40x_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  input  logic               kill_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   ptr_o
);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] mask, masked, sel_vec;
  logic [IDX_W-1:0]   winner;
  logic               no_ones;

  // Requests at or above the pointer win first; fall back to the raw vector on wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(ptr_q));
    end
    masked  = req_i & mask;
    sel_vec = (|masked) ? masked : req_i;
  end

  // Find-first-one: lowest set index of the selected vector, plus the "no winner" flag.
  always_comb begin : ff1
    winner  = '0;
    no_ones = 1'b1;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (sel_vec[i]) begin
        winner  = IDX_W'(i);
        no_ones = 1'b0;
      end
    end
  end

  always_comb begin
    gnt_d         = '0;
    gnt_d[winner] = 1'b1;
    ptr_d         = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!no_ones) begin
            gnt_q     <= gnt_d;
            gnt_idx_q <= winner;
            ptr_q     <= ptr_d;
            state_q   <= GRANTED;
          end
        end
        GRANTED: begin
          // Kill wins over done and leaves one bubble cycle before the next grant.
          if (kill_i) begin
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            state_q   <= IDLE;
          end else if (done_i) begin
            if (!no_ones) begin
              gnt_q     <= gnt_d;
              gnt_idx_q <= winner;
              ptr_q     <= ptr_d;
            end else begin
              gnt_q     <= '0;
              gnt_idx_q <= '0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          gnt_q     <= '0;
          gnt_idx_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = |gnt_q;
  assign ptr_o       = ptr_q;

endmodule

// File: tb/tb_cv32e40x_rr_arbiter.sv
// Scoreboard bench for cv32e40x_rr_arbiter: the driver queues hand-computed
// expectations per cycle; a monitor on the falling edge pops and compares.
module tb_cv32e40x_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       kill;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic [1:0] ptr;

  cv32e40x_rr_arbiter #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .done_i     (done),
    .kill_i     (kill),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .ptr_o      (ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic [1:0] ptr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Apply inputs for one edge, then queue what the outputs must be after it.
  task automatic step(input string tag, input logic r_n, input logic [3:0] rq,
                      input logic dn, input logic kl,
                      input logic [3:0] egnt, input logic [1:0] eptr);
    exp_t e;
    rst_n = r_n;
    req   = rq;
    done  = dn;
    kill  = kl;
    @(posedge clk);
    e.tag   = tag;
    e.gnt   = egnt;
    e.idx   = onehot_idx(egnt);
    e.valid = |egnt;
    e.ptr   = eptr;
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ".gnt"},   32'(gnt),       32'(mon_e.gnt));
      check({mon_e.tag, ".idx"},   32'(gnt_idx),   32'(mon_e.idx));
      check({mon_e.tag, ".valid"}, 32'(gnt_valid), 32'(mon_e.valid));
      check({mon_e.tag, ".ptr"},   32'(ptr),       32'(mon_e.ptr));
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0; kill = 1'b0;
    #1;

    // Reset with all requests pending, then first grant
    step("rst0", 0, 4'b1111, 0, 0, 4'b0000, 2'd0);
    step("rst1", 0, 4'b1111, 0, 0, 4'b0000, 2'd0);
    step("first", 1, 4'b1111, 0, 0, 4'b0001, 2'd1);

    // Rotation: back-to-back handoffs 1,2,3,0
    step("rot1", 1, 4'b1111, 1, 0, 4'b0010, 2'd2);
    step("rot2", 1, 4'b1111, 1, 0, 4'b0100, 2'd3);
    step("rot3", 1, 4'b1111, 1, 0, 4'b1000, 2'd0);
    step("rot0", 1, 4'b1111, 1, 0, 4'b0001, 2'd1);

    // Wrap: grant 1 (ptr=2), then only 0 and 1 request
    step("wrap_g1", 1, 4'b1111, 1, 0, 4'b0010, 2'd2);
    step("wrap",    1, 4'b0011, 1, 0, 4'b0001, 2'd1);

    // Hold: grant 2, request drops for 5 cycles, grant holds
    step("hold_g2", 1, 4'b0100, 1, 0, 4'b0100, 2'd3);
    for (int i = 0; i < 5; i++) step("hold", 1, 4'b0000, 0, 0, 4'b0100, 2'd3);
    step("hold_done", 1, 4'b0000, 1, 0, 4'b0000, 2'd3);
    step("idle", 1, 4'b0000, 0, 0, 4'b0000, 2'd3);

    // Kill priority over done: one bubble, then grant 1
    step("kill_g0",  1, 4'b0001, 0, 0, 4'b0001, 2'd1);
    step("kill",     1, 4'b1111, 1, 1, 4'b0000, 2'd1);
    step("kill_nxt", 1, 4'b1111, 0, 0, 4'b0010, 2'd2);
    step("kill_only", 1, 4'b1111, 0, 1, 4'b0000, 2'd2);

    // Reset mid-grant drops the grant, then single requester 3
    step("rst_mid_g", 1, 4'b1111, 0, 0, 4'b0100, 2'd3);
    step("rst_mid",   0, 4'b1111, 1, 0, 4'b0000, 2'd0);
    step("single",    1, 4'b1000, 0, 0, 4'b1000, 2'd0);
    for (int i = 0; i < 3; i++) step("single_re", 1, 4'b1000, 1, 0, 4'b1000, 2'd0);
    step("single_end", 1, 4'b0000, 1, 0, 4'b0000, 2'd0);

    // IDLE ignores done and kill
    step("idle_dk", 1, 4'b0000, 1, 1, 4'b0000, 2'd0);
    step("idle_req2", 1, 4'b0100, 0, 0, 4'b0100, 2'd3);

    done = 1'b0; kill = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
